// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch/load-store requesters, the arbiter and the memory.
// slave: arbiter view; master: requester/memory environment view.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic [DW-1:0] ls_rdata;
    logic          ls_done;
    logic          acc_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          busy;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ack,
        output if_rdata, if_valid, ls_rdata, ls_done, acc_err,
               mem_req, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_valid, ls_rdata, ls_done, acc_err,
               mem_req, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Load/store wins ties; every access runs IDLE -> REQ -> DONE with registered outputs.
module mem_port_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input logic                i_clk,
    input logic                i_rst,
    mem_port_arbiter_if.slave  bus
);
    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t        r_state;
    logic          r_owner_ls;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_ls_rdata;
    logic          r_if_valid;
    logic          r_ls_done;
    logic          r_acc_err;
    logic          r_busy;
    logic [CW-1:0] r_wait_cnt;
    logic [CW-1:0] w_wait_nxt;
    logic          w_timeout;

    assign w_wait_nxt = r_wait_cnt + CW'(1);
    assign w_timeout  = (w_wait_nxt == CW'(MAX_WAIT));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_owner_ls <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_ls_rdata <= '0;
            r_if_valid <= 1'b0;
            r_ls_done  <= 1'b0;
            r_acc_err  <= 1'b0;
            r_busy     <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_if_valid <= 1'b0;
            r_ls_done  <= 1'b0;
            r_acc_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.ls_req) begin
                        r_owner_ls <= 1'b1;
                        r_addr     <= bus.ls_addr;
                        r_mem_we   <= bus.ls_we;
                        r_wdata    <= bus.ls_wdata;
                        r_wait_cnt <= '0;
                        r_mem_req  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_REQ;
                    end else if (bus.if_req) begin
                        r_owner_ls <= 1'b0;
                        r_addr     <= bus.if_addr;
                        r_mem_we   <= 1'b0;
                        r_wdata    <= '0;
                        r_wait_cnt <= '0;
                        r_mem_req  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Done pulses are set here so they appear during the DONE cycle.
                    if (bus.mem_ack || w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_acc_err <= !bus.mem_ack;
                        r_state   <= S_DONE;
                        if (r_owner_ls) begin
                            r_ls_done  <= 1'b1;
                            r_ls_rdata <= (bus.mem_ack && !r_mem_we) ? bus.mem_rdata : '0;
                        end else begin
                            r_if_valid <= 1'b1;
                            r_if_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
                        end
                    end else begin
                        r_wait_cnt <= w_wait_nxt;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_valid  = r_if_valid;
    assign bus.ls_rdata  = r_ls_rdata;
    assign bus.ls_done   = r_ls_done;
    assign bus.acc_err   = r_acc_err;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single accesses plus
// hand-written collision, reset-mid-access and stray-ack sequences.
module tb_mem_port_arbiter;
    localparam int unsigned AW       = 32;
    localparam int unsigned DW       = 32;
    localparam int unsigned MAX_WAIT = 15;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus();

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        is_ls;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] mem_data;
        logic        drop;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " mem_req"},  bus.mem_req,  1'b0);
        chk({tag, " if_valid"}, bus.if_valid, 1'b0);
        chk({tag, " ls_done"},  bus.ls_done,  1'b0);
        chk({tag, " acc_err"},  bus.acc_err,  1'b0);
        chk({tag, " busy"},     bus.busy,     1'b0);
    endtask

    // Caller must be at a negedge in an IDLE cycle; returns at the negedge of the next IDLE cycle.
    task automatic access(input vec_t v, input string tag);
        int last;
        if (v.is_ls) begin
            bus.ls_req   = 1'b1;
            bus.ls_we    = v.we;
            bus.ls_addr  = v.addr;
            bus.ls_wdata = v.wdata;
        end else begin
            bus.if_req   = 1'b1;
            bus.if_addr  = v.addr;
            bus.ls_we    = 1'b1;
            bus.ls_wdata = 32'h5A5A_5A5A;
        end
        bus.mem_rdata = v.mem_data;
        @(negedge clk);
        if (v.is_ls) begin
            bus.ls_addr  = ~v.addr;
            bus.ls_wdata = ~v.wdata;
            bus.ls_we    = ~v.we;
            if (v.drop) bus.ls_req = 1'b0;
        end else begin
            bus.if_addr = ~v.addr;
            if (v.drop) bus.if_req = 1'b0;
        end
        last = (v.delay < int'(MAX_WAIT)) ? v.delay : int'(MAX_WAIT) - 1;
        for (int c = 0; c <= last; c++) begin
            chk({tag, " req mem_req"},  bus.mem_req,  1'b1);
            chk({tag, " req mem_addr"}, bus.mem_addr, v.addr);
            chk({tag, " req mem_we"},   bus.mem_we,   v.is_ls & v.we);
            if (v.is_ls) chk({tag, " req mem_wdata"}, bus.mem_wdata, v.wdata);
            chk({tag, " req busy"},     bus.busy,     1'b1);
            chk({tag, " req pulses"},   {bus.if_valid, bus.ls_done}, 2'b00);
            bus.mem_ack = (c == v.delay);
            @(negedge clk);
            bus.mem_ack = 1'b0;
        end
        chk({tag, " done mem_req"},  bus.mem_req,  1'b0);
        chk({tag, " done mem_we"},   bus.mem_we,   1'b0);
        chk({tag, " done if_valid"}, bus.if_valid, !v.is_ls);
        chk({tag, " done ls_done"},  bus.ls_done,  v.is_ls);
        chk({tag, " done acc_err"},  bus.acc_err,  v.exp_err);
        chk({tag, " done busy"},     bus.busy,     1'b1);
        if (v.is_ls) chk({tag, " done ls_rdata"}, bus.ls_rdata, v.exp_rdata);
        else         chk({tag, " done if_rdata"}, bus.if_rdata, v.exp_rdata);
        if (v.is_ls) bus.ls_req = 1'b0;
        else         bus.if_req = 1'b0;
        @(negedge clk);
        chk_idle_outputs({tag, " idle"});
    endtask

    initial begin
        vec_t va;
        vec_t vb;
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          2,  32'hE281_1001, 1'b0, 32'hE281_1001, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0080, 32'hDEAD_BEEF,  0,  32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,          1,  32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0,          0,  32'hA5A5_0F0F, 1'b1, 32'hA5A5_0F0F, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,          14, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0048, 32'h0,          99, 32'h5555_5555, 1'b0, 32'h0,         1'b1};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0018, 32'h0,          3,  32'h1357_9BDF, 1'b0, 32'h1357_9BDF, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 32'h0000_001C, 32'h0,          99, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b1};
        vecs[8] = '{1'b1, 1'b1, 32'h0000_0084, 32'hCAFE_F00D,  4,  32'h7777_7777, 1'b1, 32'h0,         1'b0};

        rst          = 1'b1;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.ls_req   = 1'b0;
        bus.ls_we    = 1'b0;
        bus.ls_addr  = '0;
        bus.ls_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_ack  = 1'b0;
        #1;
        chk_idle_outputs("reset");
        chk("reset mem_addr", {bus.mem_addr, bus.mem_wdata}, 64'h0);
        chk("reset rdata", {bus.if_rdata, bus.ls_rdata}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("post-reset");

        for (int i = 0; i < 9; i++) access(vecs[i], $sformatf("v%0d", i));

        // Simultaneous requests: load goes first while fetch stays pending.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0050;
        va = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0000_4040, 1'b0, 32'h0000_4040, 1'b0};
        access(va, "coll ls");
        chk("coll if still pending", bus.if_req, 1'b1);
        vb = '{1'b0, 1'b0, 32'h0000_0050, 32'h0, 0, 32'hE000_0050, 1'b0, 32'hE000_0050, 1'b0};
        access(vb, "coll if");

        // Stray acks while IDLE must not start or finish anything.
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle_outputs($sformatf("stray ack %0d", i));
        end
        bus.mem_ack = 1'b0;

        // Reset asserted mid-REQ: access is lost, no done pulse.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0030;
        @(negedge clk);
        chk("rst pre mem_req", bus.mem_req, 1'b1);
        chk("rst pre mem_addr", bus.mem_addr, 32'h0000_0030);
        #2 rst = 1'b1;
        #1;
        chk_idle_outputs("rst async");
        chk("rst async mem_addr", bus.mem_addr, 32'h0);
        @(negedge clk);
        bus.if_req = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle_outputs($sformatf("rst after %0d", i));
        end
        va = '{1'b1, 1'b0, 32'h0000_0060, 32'h0, 2, 32'h6666_0060, 1'b0, 32'h6666_0060, 1'b0};
        access(va, "post-rst ls");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
